// File: rtl/lcd_sched_pkg.sv
// Shared types and defaults for the LCD FIFO fill scheduler.
package lcd_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SYNC = 3'd1,
        ST_REFILL    = 3'd2,
        ST_BURST     = 3'd3,
        ST_FRAME_END = 3'd4
    } sched_state_e;

    localparam int unsigned DEF_ALMOSTFULL_DEPTH  = 32'd768;
    localparam int unsigned DEF_ALMOSTEMPTY_DEPTH = 32'd256;
    localparam int unsigned DEF_BURST_LEN         = 32'd64;
    localparam int unsigned DEF_H_ACTIVE          = 32'd800;
    localparam int unsigned DEF_V_ACTIVE          = 32'd480;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_pix_counter.sv
// Pixel position counter: tracks the position of the next pixel to be written.
// restart_i marks the advancing beat as pixel (0,0) regardless of position.
module lcd_pix_counter
    import lcd_sched_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic adv_i,
    input  logic restart_i,
    output logic first_o,
    output logic last_o
);

    localparam int unsigned XW = (H_ACTIVE > 32'd1) ? $clog2(H_ACTIVE) : 32'd1;
    localparam int unsigned YW = (V_ACTIVE > 32'd1) ? $clog2(V_ACTIVE) : 32'd1;
    localparam logic [XW-1:0] X_ZERO = {XW{1'b0}};
    localparam logic [YW-1:0] Y_ZERO = {YW{1'b0}};
    localparam logic [XW-1:0] X_ONE  = XW'(32'd1);
    localparam logic [YW-1:0] Y_ONE  = YW'(32'd1);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 32'd1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 32'd1);

    logic [XW-1:0] x_q, x_d, base_x_s;
    logic [YW-1:0] y_q, y_d, base_y_s;

    // Position after the current beat: x wraps into the next line, y wraps into the next frame.
    always_comb begin
        base_x_s = restart_i ? X_ZERO : x_q;
        base_y_s = restart_i ? Y_ZERO : y_q;
        x_d      = base_x_s;
        y_d      = base_y_s;
        if (base_x_s == X_LAST) begin
            x_d = X_ZERO;
            if (base_y_s == Y_LAST) begin
                y_d = Y_ZERO;
            end else begin
                y_d = base_y_s + Y_ONE;
            end
        end else begin
            x_d = base_x_s + X_ONE;
            y_d = base_y_s;
        end
    end

    // Position register: cleared on reset/clear, moves only on accepted beats.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q <= X_ZERO;
            y_q <= Y_ZERO;
        end else if (clr_i) begin
            x_q <= X_ZERO;
            y_q <= Y_ZERO;
        end else if (adv_i) begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign first_o = (x_q == X_ZERO) && (y_q == Y_ZERO);
    assign last_o  = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/lcd_fifo_fill_sched.sv
// Frame-aware scheduler moving AXI stream pixels into the LCD write FIFO.
// Requests bursts from the FIFO level, locks to frame sync and counts pixels.
module lcd_fifo_fill_sched
    import lcd_sched_pkg::*;
#(
    parameter int unsigned FIFO_ALMOSTFULL_DEPTH  = DEF_ALMOSTFULL_DEPTH,
    parameter int unsigned FIFO_ALMOSTEMPTY_DEPTH = DEF_ALMOSTEMPTY_DEPTH,
    parameter int unsigned BURST_LEN              = DEF_BURST_LEN,
    parameter int unsigned H_ACTIVE               = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE               = DEF_V_ACTIVE
) (
    input  logic        fifo_wr_clk,
    input  logic        rst,
    input  logic        sched_en,
    input  logic        axis_data_en,
    input  logic        axis_data_sync,
    output logic        axis_data_requst,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    input  logic [9:0]  fifo_wr_cnt,
    output logic        lcd_framesync,
    output logic        frame_done,
    output logic        sync_err,
    output logic [15:0] drop_cnt
);

    localparam logic [9:0] AF_LVL      = 10'(FIFO_ALMOSTFULL_DEPTH);
    localparam logic [9:0] AE_LVL      = 10'(FIFO_ALMOSTEMPTY_DEPTH);
    localparam logic [9:0] BURST_LEN_C = 10'(BURST_LEN);

    sched_state_e state_q, state_d;
    logic [9:0]   beat_cnt_q, beat_cnt_d;
    logic         req_q;
    logic         framesync_q;
    logic         frame_done_q;
    logic         sync_err_q;
    logic [15:0]  drop_cnt_q;

    logic wr_en_s;
    logic restart_s;
    logic mid_sync_s;
    logic last_beat_s;
    logic drop_s;
    logic level_hi_s;
    logic level_lo_s;
    logic burst_last_s;
    logic pix_first_s;
    logic pix_last_s;

    // Accepted beat decode: only in BURST, or the sync beat that opens a frame.
    assign wr_en_s      = axis_data_en & ~fifo_full &
                          ((state_q == ST_BURST) | ((state_q == ST_WAIT_SYNC) & axis_data_sync));
    assign restart_s    = wr_en_s & axis_data_sync;
    assign mid_sync_s   = restart_s & (state_q == ST_BURST) & ~pix_first_s;
    // A sync beat is always pixel (0,0), so it can never close a frame.
    assign last_beat_s  = wr_en_s & ~axis_data_sync & pix_last_s;
    assign drop_s       = axis_data_en & fifo_full & (state_q == ST_BURST);
    assign level_hi_s   = (fifo_wr_cnt >= AF_LVL);
    assign level_lo_s   = (fifo_wr_cnt < AE_LVL);
    assign burst_last_s = ((beat_cnt_q + 10'd1) == BURST_LEN_C);

    lcd_pix_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_pix_counter (
        .clk_i     (fifo_wr_clk),
        .rst_i     (rst),
        .clr_i     (~sched_en),
        .adv_i     (wr_en_s),
        .restart_i (restart_s),
        .first_o   (pix_first_s),
        .last_o    (pix_last_s)
    );

    // Next state and burst beat count; frame end has priority over ending the burst.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        if (!sched_en) begin
            state_d    = ST_IDLE;
            beat_cnt_d = 10'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_SYNC;
                end
                ST_WAIT_SYNC: begin
                    if (restart_s) begin
                        state_d    = ST_BURST;
                        beat_cnt_d = 10'd1;
                    end else begin
                        state_d = ST_WAIT_SYNC;
                    end
                end
                ST_REFILL: begin
                    if (level_lo_s && !fifo_full) begin
                        state_d    = ST_BURST;
                        beat_cnt_d = 10'd0;
                    end else begin
                        state_d = ST_REFILL;
                    end
                end
                ST_BURST: begin
                    if (wr_en_s) begin
                        beat_cnt_d = beat_cnt_q + 10'd1;
                    end else begin
                        beat_cnt_d = beat_cnt_q;
                    end
                    if (last_beat_s) begin
                        state_d = ST_FRAME_END;
                    end else if ((wr_en_s && burst_last_s) || level_hi_s) begin
                        state_d = ST_REFILL;
                    end else begin
                        state_d = ST_BURST;
                    end
                end
                ST_FRAME_END: begin
                    state_d = ST_WAIT_SYNC;
                end
                default: begin
                    state_d    = ST_IDLE;
                    beat_cnt_d = 10'd0;
                end
            endcase
        end
    end

    // FSM state, beat counter, request, pulse and drop registers.
    always_ff @(posedge fifo_wr_clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= 10'd0;
            req_q        <= 1'b0;
            framesync_q  <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            drop_cnt_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            req_q        <= (state_d == ST_WAIT_SYNC) || (state_d == ST_BURST);
            framesync_q  <= restart_s;
            frame_done_q <= last_beat_s;
            sync_err_q   <= mid_sync_s;
            if (drop_s) begin
                drop_cnt_q <= sat_inc16(drop_cnt_q);
            end
        end
    end

    assign axis_data_requst = req_q;
    assign fifo_wr_en       = wr_en_s;
    assign lcd_framesync    = framesync_q;
    assign frame_done       = frame_done_q;
    assign sync_err         = sync_err_q;
    assign drop_cnt         = drop_cnt_q;

endmodule

// File: tb/tb_lcd_fifo_fill_sched.sv
// Directed bench for lcd_fifo_fill_sched with an 8x4 frame and 4-beat bursts.
module tb_lcd_fifo_fill_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        sched_en;
    logic        axis_data_en;
    logic        axis_data_sync;
    logic        axis_data_requst;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic [9:0]  fifo_wr_cnt;
    logic        lcd_framesync;
    logic        frame_done;
    logic        sync_err;
    logic [15:0] drop_cnt;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_wr;
    logic prev_wr;
    logic seen;

    always #5 clk = ~clk;

    lcd_fifo_fill_sched #(
        .FIFO_ALMOSTFULL_DEPTH  (768),
        .FIFO_ALMOSTEMPTY_DEPTH (256),
        .BURST_LEN              (4),
        .H_ACTIVE               (8),
        .V_ACTIVE               (4)
    ) dut (
        .fifo_wr_clk      (clk),
        .rst              (rst),
        .sched_en         (sched_en),
        .axis_data_en     (axis_data_en),
        .axis_data_sync   (axis_data_sync),
        .axis_data_requst (axis_data_requst),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_full        (fifo_full),
        .fifo_wr_cnt      (fifo_wr_cnt),
        .lcd_framesync    (lcd_framesync),
        .frame_done       (frame_done),
        .sync_err         (sync_err),
        .drop_cnt         (drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic r, input logic s_en, input logic en, input logic sy,
                         input logic fu, input logic [9:0] lvl);
        @(negedge clk);
        rst            = r;
        sched_en       = s_en;
        axis_data_en   = en;
        axis_data_sync = sy;
        fifo_full      = fu;
        fifo_wr_cnt    = lvl;
        #1;
    endtask

    // Stream beats until frame_done shows up; counts writes before it.
    task automatic run_to_done(input int start_n, input int budget,
                               output int cnt_o, output logic prev_o, output logic seen_o);
        cnt_o  = start_n;
        prev_o = 1'b0;
        seen_o = 1'b0;
        for (int i = 0; i < budget && !seen_o; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd100);
            if (frame_done === 1'b1) begin
                seen_o = 1'b1;
            end else begin
                prev_o = fifo_wr_en;
                if (fifo_wr_en === 1'b1) cnt_o++;
            end
        end
    endtask

    // Stream beats until the write count reaches target.
    task automatic run_writes(input int start_n, input int target, input int budget,
                              output int cnt_o);
        cnt_o = start_n;
        for (int i = 0; i < budget && cnt_o < target; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd100);
            if (fifo_wr_en === 1'b1) cnt_o++;
        end
    endtask

    initial begin
        rst = 1'b1; sched_en = 1'b0; axis_data_en = 1'b0; axis_data_sync = 1'b0;
        fifo_full = 1'b0; fifo_wr_cnt = 10'd0;

        // Reset state, with beat and sync presented
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0);
        chk("rst_req", axis_data_requst, 0);
        chk("rst_fs", lcd_framesync, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_err", sync_err, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_wr", fifo_wr_en, 0);

        // Lock to sync
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        chk("t1_idle_req", axis_data_requst, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
        chk("t1_wait_req", axis_data_requst, 1);
        chk("t1_nosync_wr", fifo_wr_en, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
        chk("t1_nosync_wr2", fifo_wr_en, 0);
        chk("t1_nosync_drop", drop_cnt, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0);
        chk("t1_sync_wr", fifo_wr_en, 1);
        chk("t1_fs_early", lcd_framesync, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd100);
        chk("t1_fs", lcd_framesync, 1);
        chk("t1_req_hold", axis_data_requst, 1);
        chk("t2_wr_b2", fifo_wr_en, 1);

        // Burst of 4 then refill
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd100);
        chk("t2_fs_pulse", lcd_framesync, 0);
        chk("t2_wr_b3", fifo_wr_en, 1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd100);
        chk("t2_wr_b4", fifo_wr_en, 1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd100);
        chk("t2_refill_req", axis_data_requst, 0);
        chk("t2_refill_wr", fifo_wr_en, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd100);
        chk("t2_reburst_req", axis_data_requst, 1);
        chk("t2_reburst_wr", fifo_wr_en, 1);

        // Rest of the 32-pixel frame
        run_to_done(5, 80, n_wr, prev_wr, seen);
        chk("t3_done_seen", seen, 1);
        chk("t3_pixels", n_wr, 32);
        chk("t3_prev_wr", prev_wr, 1);
        chk("t3_fe_wr", fifo_wr_en, 0);
        chk("t3_fe_req", axis_data_requst, 0);
        chk("t3_fe_err", sync_err, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd100);
        chk("t3_ws_fd", frame_done, 0);
        chk("t3_ws_req", axis_data_requst, 1);
        chk("t3_ws_wr", fifo_wr_en, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd100);
        chk("t3_ws_wr2", fifo_wr_en, 0);

        // fifo_full drops inside a burst
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd100);
        chk("t4_sync_wr", fifo_wr_en, 1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd100);
        chk("t4_full_wr1", fifo_wr_en, 0);
        chk("t4_fs", lcd_framesync, 1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd100);
        chk("t4_full_wr2", fifo_wr_en, 0);
        chk("t4_drop1", drop_cnt, 1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd100);
        chk("t4_full_wr3", fifo_wr_en, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd100);
        chk("t4_drop3", drop_cnt, 3);
        chk("t4_resume_wr", fifo_wr_en, 1);
        run_to_done(2, 80, n_wr, prev_wr, seen);
        chk("t4_done_seen", seen, 1);
        chk("t4_pixels", n_wr, 32);

        // Sync arriving at pixel 13
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd100);
        chk("t5_sync_wr", fifo_wr_en, 1);
        run_writes(1, 13, 60, n_wr);
        chk("t5_pre_pixels", n_wr, 13);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd100);
        chk("t5_mid_wr", fifo_wr_en, 1);
        chk("t5_err_early", sync_err, 0);
        n_wr = 1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd100);
        chk("t5_err", sync_err, 1);
        chk("t5_fs", lcd_framesync, 1);
        chk("t5_no_fd", frame_done, 0);
        if (fifo_wr_en === 1'b1) n_wr++;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd100);
        chk("t5_err_pulse", sync_err, 0);
        if (fifo_wr_en === 1'b1) n_wr++;
        run_to_done(n_wr, 80, n_wr, prev_wr, seen);
        chk("t5_done_seen", seen, 1);
        chk("t5_pixels", n_wr, 32);
        chk("t5_drop_hold", drop_cnt, 3);

        // Level high, sched_en low, reset mid-burst
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd100);
        chk("t6_sync_wr", fifo_wr_en, 1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd800);
        chk("t6_burst_req", axis_data_requst, 1);
        chk("t6_hi_wr", fifo_wr_en, 1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd100);
        chk("t6_hi_req", axis_data_requst, 0);
        chk("t6_hi_wr_drop", fifo_wr_en, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd100);
        chk("t6_lo_req", axis_data_requst, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd100);
        chk("t6_dis_wr", fifo_wr_en, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd100);
        chk("t6_dis_req", axis_data_requst, 0);
        chk("t6_dis_wr2", fifo_wr_en, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd100);
        chk("t6_idle_sync_wr", fifo_wr_en, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd100);
        chk("t6_rearm_req", axis_data_requst, 1);
        chk("t6_rearm_wr", fifo_wr_en, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd100);
        chk("t6_pre_rst_fs", lcd_framesync, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd100);
        chk("t6_rst_req", axis_data_requst, 0);
        chk("t6_rst_fs", lcd_framesync, 0);
        chk("t6_rst_fd", frame_done, 0);
        chk("t6_rst_err", sync_err, 0);
        chk("t6_rst_drop", drop_cnt, 0);
        chk("t6_rst_wr", fifo_wr_en, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
